// File: rtl/tick_sched_pkg.sv
// -----------------------------------------------------------------------------
// tick_sched_pkg
// Shared definitions for the tick scheduler: the FSM state encoding, the
// default counter width and the half-period count of the ~3 Hz display clock.
// No ports (package).
// -----------------------------------------------------------------------------
package tick_sched_pkg;

    // 25 bits is enough to hold the 3 Hz half-period count below
    localparam int CW_DEFAULT = 25;

    // half period of the ~3 Hz display clock, in system clock cycles
    localparam int DIV_3HZ = 8333333;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans the request vector starting
// at the pointer position and wrapping modulo NREQ; the first asserted request
// found wins.
//
// Ports:
//   i_req  [NREQ-1:0] : request vector
//   i_ptr  [IW-1:0]   : index where the search starts
//   o_pick [NREQ-1:0] : one-hot winner (all zero when i_req is zero)
//   o_idx  [IW-1:0]   : binary index of the winner (0 when i_req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_pick,
    output logic [IW-1:0]   o_idx
);

    // Walk the rotated positions from farthest to nearest so that the last
    // hit written is the one closest to the pointer, i.e. the round-robin
    // winner. This keeps the loop free of any early-exit construct.
    always_comb begin
        int w_pos;
        o_pick = '0;
        o_idx  = '0;
        w_pos  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_pos]) begin
                o_pick        = '0;
                o_pick[w_pos] = 1'b1;
                o_idx         = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
// One shared programmable down-counter handed out to NREQ requesters in
// round-robin order. Each granted requester has its own wait length counted
// out and receives a single-cycle done pulse at the end.
//
// Ports:
//   inp_clk                 : system clock, rising edge
//   rst_n                   : asynchronous active-low reset
//   req      [NREQ-1:0]     : level requests, held until done or abort
//   div_flat [NREQ*CW-1:0]  : packed wait lengths, div[i] = div_flat[i*CW +: CW]
//   grant    [NREQ-1:0]     : one-hot owner while the job is in LOAD or COUNT
//   done     [NREQ-1:0]     : one-hot single-cycle completion pulse
//   busy                    : high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                 inp_clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   div_flat,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t    r_state;
    sched_state_t    w_stateNext;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic            r_busy;

    logic [NREQ-1:0] w_pick;
    logic [IW-1:0]   w_pickIdx;
    logic [CW-1:0]   w_divSel;
    logic            w_reqOwner;
    logic [NREQ-1:0] w_ownerHot;
    logic [NREQ-1:0] w_grantNext;
    logic [NREQ-1:0] w_doneNext;
    logic            w_busyNext;
    logic            w_ptrAdvance;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req  (req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_idx  (w_pickIdx)
    );

    assign w_divSel   = div_flat[int'(r_idx)*CW +: CW];
    assign w_reqOwner = req[r_idx];
    assign w_ownerHot = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;

    // State register. Reset drops straight back to IDLE, abandoning any job.
    always_ff @(posedge inp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-output decode. The outputs are registered, so the
    // values computed here describe the state being entered. Losing the
    // owner's request in LOAD or COUNT wins over reaching zero, so an abort
    // on the final count cycle produces no done pulse.
    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = '0;
        w_doneNext   = '0;
        w_ptrAdvance = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_stateNext = LOAD;
                    w_grantNext = w_pick;
                end
            end
            LOAD: begin
                if (!w_reqOwner) begin
                    w_stateNext  = IDLE;
                    w_ptrAdvance = 1'b1;
                end else begin
                    w_stateNext = COUNT;
                    w_grantNext = w_ownerHot;
                end
            end
            COUNT: begin
                if (!w_reqOwner) begin
                    w_stateNext  = IDLE;
                    w_ptrAdvance = 1'b1;
                end else if (r_cnt == '0) begin
                    w_stateNext = DONE;
                    w_doneNext  = w_ownerHot;
                end else begin
                    w_grantNext = w_ownerHot;
                end
            end
            DONE: begin
                w_stateNext  = IDLE;
                w_ptrAdvance = 1'b1;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    // Datapath and output registers. The wait length is captured only in
    // LOAD so later edits to div_flat do not disturb a running job; the
    // decrement only happens while staying in COUNT, which implies cnt is
    // nonzero and therefore cannot wrap.
    always_ff @(posedge inp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (r_state == IDLE && |req) begin
                r_idx <= w_pickIdx;
            end
            if (r_state == LOAD) begin
                r_cnt <= w_divSel;
            end else if (r_state == COUNT && w_stateNext == COUNT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_ptrAdvance) begin
                r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
            end
            r_grant <= w_grantNext;
            r_done  <= w_doneNext;
            r_busy  <= w_busyNext;
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;

endmodule

// File: tb/tb_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_scheduler
// Self-checking bench for tick_scheduler. A timeline model tracks the current
// job as (owner, start edge, done edge) and derives grant/done/busy from the
// edge number; it is compared against the DUT after every clock edge, with
// extra directed checks on latencies and serving order.
// -----------------------------------------------------------------------------
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int CW   = CW_DEFAULT;

    logic                inp_clk = 1'b0;
    logic                rst_n   = 1'b0;
    logic [NREQ-1:0]     req     = '0;
    logic [NREQ*CW-1:0]  div_flat = '0;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic                busy;

    int total = 0;
    int bad   = 0;

    // model of the job in flight
    bit mActive   = 1'b0;
    int mOwner    = 0;
    int mStart    = 0;
    int mDoneEdge = 0;
    int mPtr      = 0;
    int edgeNum   = 0;

    always #5 inp_clk = ~inp_clk;

    tick_scheduler #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .inp_clk  (inp_clk),
        .rst_n    (rst_n),
        .req      (req),
        .div_flat (div_flat),
        .grant    (grant),
        .done     (done),
        .busy     (busy)
    );

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        req = r;
    endtask

    task automatic setDiv(input int i, input int v);
        div_flat[i*CW +: CW] = CW'(v);
    endtask

    function automatic int oneHotIdx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic modelReset();
        mActive = 1'b0;
        mPtr    = 0;
    endtask

    // Advance the timeline model by one rising edge using the inputs that the
    // DUT sees at that same edge.
    task automatic modelEdge();
        int pick;
        edgeNum++;
        if (mActive) begin
            if (edgeNum == mStart + 1) begin
                mDoneEdge = mStart + int'(div_flat[mOwner*CW +: CW]) + 2;
            end
            if (edgeNum >= mStart + 1 && edgeNum <= mDoneEdge && !req[mOwner]) begin
                mActive = 1'b0;
                mPtr    = (mOwner + 1) % NREQ;
            end else if (edgeNum == mDoneEdge + 1) begin
                mActive = 1'b0;
                mPtr    = (mOwner + 1) % NREQ;
            end
        end else if (req != '0) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (pick < 0 && req[(mPtr + k) % NREQ]) pick = (mPtr + k) % NREQ;
            end
            mActive   = 1'b1;
            mOwner    = pick;
            mStart    = edgeNum;
            mDoneEdge = 1 << 30;
        end
    endtask

    // One clock: update the model at the edge, then compare 1 time unit later
    task automatic stepCycle(input string tag);
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ed;
        logic            eb;
        @(posedge inp_clk);
        if (rst_n) modelEdge();
        #1;
        eg = '0;
        ed = '0;
        eb = 1'b0;
        if (rst_n && mActive) begin
            eb = 1'b1;
            if (edgeNum < mDoneEdge) eg = NREQ'(1) << mOwner;
            else                     ed = NREQ'(1) << mOwner;
        end
        checkOutput({tag, "/grant"}, 32'(grant), 32'(eg));
        checkOutput({tag, "/done"},  32'(done),  32'(ed));
        checkOutput({tag, "/busy"},  32'(busy),  32'(eb));
    endtask

    // Step until a done pulse shows up or the budget runs out
    task automatic runUntilDone(input string tag, output int cycles, output logic [NREQ-1:0] dv);
        cycles = 0;
        dv     = '0;
        while (cycles < 400 && dv == '0) begin
            stepCycle(tag);
            cycles++;
            dv = done;
        end
        checkOutput({tag, "/seen"}, 32'(|dv), 32'(1));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        repeat (3) stepCycle("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        int              cyc;
        int              idxSeen;
        logic [NREQ-1:0] dv;
        logic [NREQ-1:0] flip;

        // reset then idle
        for (int i = 0; i < NREQ; i++) setDiv(i, 0);
        applyStimulus('0);
        doReset();
        repeat (20) stepCycle("idle");

        // single job: req[1], div 5 -> done 8 cycles after request
        setDiv(1, 5);
        applyStimulus(4'b0010);
        runUntilDone("single", cyc, dv);
        checkOutput("single/latency", 32'(cyc), 32'(8));
        checkOutput("single/who", 32'(dv), 32'(4'b0010));
        applyStimulus('0);
        repeat (4) stepCycle("single_tail");

        // round-robin from ptr 0 with all lengths 2
        doReset();
        for (int i = 0; i < NREQ; i++) setDiv(i, 2);
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            runUntilDone("rr", cyc, dv);
            idxSeen = oneHotIdx(dv);
            checkOutput("rr/order", 32'(idxSeen), 32'(k % NREQ));
            checkOutput("rr/gap", 32'(cyc), (k == 0) ? 32'(5) : 32'(6));
        end
        applyStimulus('0);
        repeat (4) stepCycle("rr_tail");

        // zero-length job
        setDiv(0, 0);
        applyStimulus(4'b0001);
        runUntilDone("zero", cyc, dv);
        checkOutput("zero/latency", 32'(cyc), 32'(3));
        checkOutput("zero/who", 32'(dv), 32'(4'b0001));
        applyStimulus('0);
        repeat (3) stepCycle("zero_tail");

        // div edited mid-count is ignored
        setDiv(2, 10);
        applyStimulus(4'b0100);
        repeat (5) stepCycle("divchg");
        setDiv(2, 1);
        runUntilDone("divchg", cyc, dv);
        checkOutput("divchg/latency", 32'(cyc + 5), 32'(13));
        checkOutput("divchg/who", 32'(dv), 32'(4'b0100));
        applyStimulus('0);
        repeat (3) stepCycle("divchg_tail");

        // abort of requester 3 with requester 0 pending
        setDiv(3, 100);
        setDiv(0, 0);
        applyStimulus(4'b1001);
        repeat (20) stepCycle("abort_run");
        checkOutput("abort/owner", 32'(grant), 32'(4'b1000));
        applyStimulus(4'b0001);
        stepCycle("abort_drop");
        checkOutput("abort/cleared", 32'(grant), 32'(0));
        stepCycle("abort_next");
        checkOutput("abort/regrant", 32'(grant), 32'(4'b0001));
        runUntilDone("abort_job0", cyc, dv);
        checkOutput("abort_job0/who", 32'(dv), 32'(4'b0001));
        applyStimulus('0);
        repeat (3) stepCycle("abort_tail");

        // asynchronous reset in the middle of a count
        setDiv(1, 50);
        applyStimulus(4'b0010);
        repeat (10) stepCycle("areset_run");
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("areset/grant", 32'(grant), 32'(0));
        checkOutput("areset/busy",  32'(busy),  32'(0));
        checkOutput("areset/done",  32'(done),  32'(0));
        repeat (2) stepCycle("areset_hold");
        rst_n = 1'b1;
        setDiv(0, 3);
        setDiv(2, 3);
        applyStimulus(4'b0101);
        runUntilDone("areset_first", cyc, dv);
        checkOutput("areset_first/who", 32'(dv), 32'(4'b0001));
        runUntilDone("areset_second", cyc, dv);
        checkOutput("areset_second/who", 32'(dv), 32'(4'b0100));
        applyStimulus('0);
        repeat (3) stepCycle("areset_tail");

        // randomized traffic: bits flip occasionally, lengths change at will
        flip = '0;
        for (int c = 0; c < 800; c++) begin
            flip = '0;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(15) == 0) flip[i] = 1'b1;
            end
            applyStimulus(req ^ flip);
            if ($urandom_range(7) == 0) setDiv(int'($urandom_range(NREQ - 1)), int'($urandom_range(6)));
            stepCycle("rand");
        end
        applyStimulus('0);
        repeat (20) stepCycle("rand_tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
